spike_rate_decoder: RTL
=======================

# spike_rate_decoder

Receive-side decoder for the LIF neuron spike stream. Samples a 1-bit spike train over fixed windows and reports two values per window: the spike count (rate code) and the time to the first spike (latency code). Results leave through a one-deep valid/ready output register. Sits after the neuron's spike output and converts spiking activity back into multi-bit values for downstream logic or a bench scoreboard.

## Interface
- WINDOW, 16: window length in sampled cycles; must be ≥ 2.
- OUT_W, 8: width of rate_out; counts above 2^OUT_W−1 saturate.
- TW, $clog2(WINDOW+1): width of first_spike; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  run windows while high; low aborts the current window.
- spike_in  in  1  spike train, one sample per clk.
- rate_out  out  OUT_W  spike count of the last completed window.
- first_spike  out  TW  sample index (0..WINDOW−1) of the first spike; WINDOW if the window had no spike.
- rate_valid  out  1  rate_out and first_spike hold a result.
- rate_ready  in  1  consumer accepts the result.
- overrun  out  1  one-cycle pulse: a completed window was dropped.
- busy  out  1  high while in COUNT.

## Operation
- FSM has two states, IDLE and COUNT; reset enters IDLE.
- IDLE → COUNT at a clock edge where enable=1. That edge does not sample spike_in. idx=0, cnt=0, first=WINDOW, seen=0.
- COUNT, at each edge with enable=1:
  - Sample spike_in at index idx.
  - If spike_in=1: cnt saturating-increments. If seen=0, first←idx and seen←1.
  - idx increments.
- At the edge that samples idx=WINDOW−1, the window completes:
  - The final count and first-spike value include that edge's sample.
  - The next window starts immediately: idx=0, cnt=0, first=WINDOW, seen=0, state stays COUNT. There is no gap between windows.
- COUNT with enable=0 at an edge: the partial window is discarded, state goes to IDLE, and no result is produced.
- Output register, on window completion:
  - If rate_valid=0, or rate_valid=1 and rate_ready=1 on the same edge, load the new result and set rate_valid=1.
  - Otherwise keep the held result unchanged, drop the new one, and pulse overrun for one cycle.
- rate_valid=1 and rate_ready=1 with no completion on that edge: rate_valid←0. rate_out and first_spike keep their last values.
- rate_out and first_spike are stable whenever rate_valid=1.
- rate_ready is ignored while rate_valid=0.
- busy = (state == COUNT).

## Timing
- Reset values: rate_out=0, first_spike=0, rate_valid=0, overrun=0, busy=0, state=IDLE.
- Reset asserted mid-window or with a result held: everything clears immediately, with no completion and no overrun.
- Windows are numbered by their enabling edge E0. Window n samples edges E0+nW+1 … E0+(n+1)W, where W=WINDOW.
- Window n completes at edge E0+(n+1)W. rate_valid is visible in the cycle after that edge, so latency is 0 cycles after the last sample.
- With rate_ready held high, rate_valid pulses for one cycle every WINDOW cycles.
- Simultaneous accept and completion on one edge: the new result loads and rate_valid stays 1, with no bubble.
- enable dropping on the completion edge: no completion is taken; the partial window is discarded.
- All outputs are registered, with no combinational path from any input to any output.

## Test plan
1. **Reset:** assert reset mid-window with a result held → all outputs 0 immediately. After release with enable=0, busy=0 and rate_valid=0.
2. **Saturating input:** WINDOW=16, enable=1 at E0, spike_in=1 constant, rate_ready=1 → rate_out=16 and first_spike=0, with rate_valid high one cycle after E0+16, E0+32, and so on.
3. **Sparse spikes:** spikes at sample indices 3, 7 and 11 → rate_out=3, first_spike=3. The next window, with no spikes, gives rate_out=0 and first_spike=16.
4. **Backpressure:** rate_ready=0 across two windows → window 0's result is held. At E0+32, overrun pulses for exactly one cycle and rate_out is unchanged. Raising rate_ready then clears rate_valid, and window 2's result arrives at E0+48.
5. **Abort:** enable drops after sample index 8 → busy=0 and no rate_valid. Re-enabling starts a fresh window with idx=0, and its count excludes the aborted samples.
6. **Saturation:** OUT_W=3, WINDOW=16, constant spikes → rate_out=7, first_spike=0.

Source files
------------

// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_rate_decoder
// Description : Converts a 1-bit spike train into a per-window spike count
//               (rate code) and first-spike index (latency code). Results are
//               presented through a one-deep valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_decoder #(
  parameter int WINDOW = 16,
  parameter int OUT_W  = 8,
  parameter int TW     = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_in,
  output logic [OUT_W-1:0] rate_out,
  output logic [TW-1:0]    first_spike,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic             busy
);

  localparam logic [TW-1:0]    C_LAST = TW'(WINDOW - 1);
  localparam logic [TW-1:0]    C_NONE = TW'(WINDOW);
  localparam logic [OUT_W-1:0] C_SAT  = {OUT_W{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_idx;
  logic [OUT_W-1:0] r_cnt;
  logic [TW-1:0]    r_first;
  logic             r_seen;

  logic [OUT_W-1:0] r_rate;
  logic [TW-1:0]    r_first_out;
  logic             r_valid;
  logic             r_overrun;

  logic             w_sample;
  logic             w_complete;
  logic             w_load;
  logic [OUT_W-1:0] w_cnt_next;
  logic [TW-1:0]    w_first_next;

  // Window bookkeeping including the current edge's sample; these values
  // feed both the running registers and the output register on completion.
  always_comb begin
    w_sample     = (r_state == S_COUNT) && enable;
    w_complete   = w_sample && (r_idx == C_LAST);
    w_load       = w_complete && (!r_valid || rate_ready);
    w_cnt_next   = r_cnt;
    w_first_next = r_first;
    if (spike_in) begin
      if (r_cnt != C_SAT) begin
        w_cnt_next = r_cnt + OUT_W'(1);
      end
      if (!r_seen) begin
        w_first_next = r_idx;
      end
    end
  end

  // Window FSM: a completed window rolls straight into the next one, and
  // dropping enable at any COUNT edge discards the partial window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_first <= C_NONE;
      r_seen  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_COUNT;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_first <= C_NONE;
            r_seen  <= 1'b0;
          end
        end
        S_COUNT: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (w_complete) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_first <= C_NONE;
            r_seen  <= 1'b0;
          end else begin
            r_idx   <= r_idx + TW'(1);
            r_cnt   <= w_cnt_next;
            r_first <= w_first_next;
            r_seen  <= r_seen | spike_in;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // One-deep result register: a completion replaces the held result only if
  // the slot is empty or being drained on the same edge; otherwise it is
  // dropped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rate      <= '0;
      r_first_out <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= w_complete && r_valid && !rate_ready;
      if (w_load) begin
        r_rate      <= w_cnt_next;
        r_first_out <= w_first_next;
        r_valid     <= 1'b1;
      end else if (r_valid && rate_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rate_out    = r_rate;
  assign first_spike = r_first_out;
  assign rate_valid  = r_valid;
  assign overrun     = r_overrun;
  assign busy        = (r_state == S_COUNT);

endmodule
`default_nettype wire
